// File: rtl/dbg_apb_pkg.sv
// Shared types and helpers for the debug APB master bridge.
package dbg_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    localparam int DEFAULT_TIMEOUT = 256;

    // Select vectors wider than 32 bits are not supported by this check.
    function automatic logic is_onehot(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/dbg_apb_master_if.sv
// Request/response and APB bus signals of the debug APB master bridge.
interface dbg_apb_master_if #(
    parameter int NR_SLAVES   = 1,
    parameter int ADDR_WIDTH  = 5,
    parameter int WDATA_WIDTH = 32,
    parameter int RDATA_WIDTH = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic [ADDR_WIDTH-1:0]    req_addr;
    logic [NR_SLAVES-1:0]     req_sel;
    logic                     req_wr_rd;
    logic [WDATA_WIDTH-1:0]   req_wdata;
    logic                     rsp_valid;
    logic                     rsp_err;
    logic [RDATA_WIDTH-1:0]   rsp_rdata;
    logic [ADDR_WIDTH-1:0]    apb_addr;
    logic [NR_SLAVES-1:0]     apb_sel;
    logic                     apb_enable;
    logic                     apb_wr_rd;
    logic [WDATA_WIDTH-1:0]   apb_wdata;
    logic [WDATA_WIDTH/8-1:0] apb_wstrobe;
    logic                     apb_ready;
    logic [RDATA_WIDTH-1:0]   apb_rdata;

    modport master (
        input  req_valid, req_addr, req_sel, req_wr_rd, req_wdata,
        input  apb_ready, apb_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output apb_addr, apb_sel, apb_enable, apb_wr_rd, apb_wdata, apb_wstrobe
    );

    modport slave (
        output req_valid, req_addr, req_sel, req_wr_rd, req_wdata,
        output apb_ready, apb_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  apb_addr, apb_sel, apb_enable, apb_wr_rd, apb_wdata, apb_wstrobe
    );

endinterface

// File: rtl/dbg_apb_timeout.sv
// Saturating ACCESS-phase wait counter; flags the wait cycle that reaches TIMEOUT.
module dbg_apb_timeout #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expiring
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] SAT  = (TIMEOUT > 0) ? CW'(TIMEOUT) : {CW{1'b1}};
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != SAT)) begin
            count_q <= count_q + CW'(1);
        end
    end

    // True when one more stalled cycle would bring the count to TIMEOUT.
    assign expiring = (TIMEOUT > 0) && (count_q == LAST);

endmodule

// File: rtl/dbg_apb_master.sv
// Debug APB master bridge: one request at a time, SETUP/ACCESS sequencing,
// ready-timeout so a hung core cannot lock the debugger.
module dbg_apb_master
    import dbg_apb_pkg::*;
#(
    parameter int NR_SLAVES   = 1,
    parameter int ADDR_WIDTH  = 5,
    parameter int WDATA_WIDTH = 32,
    parameter int RDATA_WIDTH = 32,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    dbg_apb_master_if.master bus
);
    localparam int SW = WDATA_WIDTH / 8;

    apb_mst_state_e           state_q, state_d;
    logic                     req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     rsp_err_q, rsp_err_d;
    logic [RDATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0]    apb_addr_q, apb_addr_d;
    logic [NR_SLAVES-1:0]     apb_sel_q, apb_sel_d;
    logic                     apb_enable_q, apb_enable_d;
    logic                     apb_wr_rd_q, apb_wr_rd_d;
    logic [WDATA_WIDTH-1:0]   apb_wdata_q, apb_wdata_d;
    logic [SW-1:0]            apb_wstrobe_q, apb_wstrobe_d;
    logic                     cnt_clr, cnt_en, cnt_expiring;

    assign cnt_clr = (state_q != ACCESS);
    assign cnt_en  = (state_q == ACCESS) && !bus.apb_ready;

    dbg_apb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .expiring (cnt_expiring)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            apb_addr_q    <= '0;
            apb_sel_q     <= '0;
            apb_enable_q  <= 1'b0;
            apb_wr_rd_q   <= 1'b0;
            apb_wdata_q   <= '0;
            apb_wstrobe_q <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
            apb_addr_q    <= apb_addr_d;
            apb_sel_q     <= apb_sel_d;
            apb_enable_q  <= apb_enable_d;
            apb_wr_rd_q   <= apb_wr_rd_d;
            apb_wdata_q   <= apb_wdata_d;
            apb_wstrobe_q <= apb_wstrobe_d;
        end
    end

    // Outputs are registered, so each branch sets the values seen in the next state.
    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_rdata_d   = '0;
        apb_addr_d    = apb_addr_q;
        apb_sel_d     = apb_sel_q;
        apb_enable_d  = apb_enable_q;
        apb_wr_rd_d   = apb_wr_rd_q;
        apb_wdata_d   = apb_wdata_q;
        apb_wstrobe_d = apb_wstrobe_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_ready_d = 1'b0;
                    if (!is_onehot(32'(bus.req_sel))) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d       = SETUP;
                        apb_sel_d     = bus.req_sel;
                        apb_addr_d    = bus.req_addr;
                        apb_wr_rd_d   = bus.req_wr_rd;
                        apb_wdata_d   = bus.req_wdata;
                        apb_wstrobe_d = bus.req_wr_rd ? {SW{1'b1}} : {SW{1'b0}};
                    end
                end
            end
            SETUP: begin
                state_d      = ACCESS;
                apb_enable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.apb_ready) begin
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = apb_wr_rd_q ? '0 : bus.apb_rdata;
                    apb_sel_d    = '0;
                    apb_enable_d = 1'b0;
                end else if (cnt_expiring) begin
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_err_d    = 1'b1;
                    apb_sel_d    = '0;
                    apb_enable_d = 1'b0;
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.apb_addr    = apb_addr_q;
    assign bus.apb_sel     = apb_sel_q;
    assign bus.apb_enable  = apb_enable_q;
    assign bus.apb_wr_rd   = apb_wr_rd_q;
    assign bus.apb_wdata   = apb_wdata_q;
    assign bus.apb_wstrobe = apb_wstrobe_q;

endmodule

// File: tb/tb_dbg_apb_master.sv
// Scoreboard bench for dbg_apb_master: random requests against a behavioural
// APB slave and a transaction-level reference model.
module tb_dbg_apb_master;

    localparam int NS = 2;
    localparam int AW = 5;
    localparam int WW = 32;
    localparam int RW = 32;
    localparam int TO = 8;

    typedef struct {
        logic          err;
        logic [RW-1:0] rdata;
        longint        due;
    } sb_t;

    typedef struct {
        int            waits;
        logic [AW-1:0] addr;
        logic [NS-1:0] sel;
        logic          wr;
        logic [WW-1:0] wdata;
    } xfer_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int xfers     = 0;
    int exp_xfers = 0;
    int rsp_cnt   = 0;
    int exp_rsp   = 0;

    sb_t   sb[$];
    xfer_t xq[$];

    logic [WW-1:0] slv_mem   [32];
    logic [WW-1:0] model_mem [32];

    dbg_apb_master_if #(.NR_SLAVES(NS), .ADDR_WIDTH(AW), .WDATA_WIDTH(WW), .RDATA_WIDTH(RW)) bus ();

    dbg_apb_master #(
        .NR_SLAVES   (NS),
        .ADDR_WIDTH  (AW),
        .WDATA_WIDTH (WW),
        .RDATA_WIDTH (RW),
        .TIMEOUT     (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Behavioural APB slave: a fixed number of wait states per transfer, taken from xq.
    xfer_t cur;
    int    waited;
    logic  prev_en;
    logic  [NS-1:0] prev_sel;

    always @(negedge clk) begin
        if (rst) begin
            bus.apb_ready = 1'b0;
            prev_en  = 1'b0;
            prev_sel = '0;
        end else begin
            if (bus.apb_enable) begin
                if (!prev_en) begin
                    xfers++;
                    chk("setup_phase_sel", 64'(prev_sel), 64'(bus.apb_sel));
                    if (xq.size() == 0) begin
                        chk("xfer_expected", 64'(xq.size()), 64'd1);
                        cur.waits = 0; cur.addr = bus.apb_addr; cur.sel = bus.apb_sel;
                        cur.wr = bus.apb_wr_rd; cur.wdata = bus.apb_wdata;
                    end else begin
                        cur = xq.pop_front();
                    end
                    waited = 0;
                    chk("apb_sel", 64'(bus.apb_sel), 64'(cur.sel));
                    chk("apb_wr_rd", 64'(bus.apb_wr_rd), 64'(cur.wr));
                    chk("apb_wstrobe", 64'(bus.apb_wstrobe), cur.wr ? 64'hF : 64'h0);
                    if (cur.wr) chk("apb_wdata", 64'(bus.apb_wdata), 64'(cur.wdata));
                end
                chk("apb_addr_stable", 64'(bus.apb_addr), 64'(cur.addr));
                if (waited == cur.waits) begin
                    bus.apb_ready = 1'b1;
                    if (bus.apb_wr_rd) slv_mem[bus.apb_addr] = bus.apb_wdata;
                    bus.apb_rdata = slv_mem[bus.apb_addr];
                end else begin
                    bus.apb_ready = 1'b0;
                    bus.apb_rdata = $urandom;
                    waited++;
                end
            end else begin
                if (prev_en) chk("apb_sel_released", 64'(bus.apb_sel), 64'd0);
                bus.apb_ready = 1'b0;
                bus.apb_rdata = $urandom;
            end
            prev_en  = bus.apb_enable;
            prev_sel = bus.apb_sel;
        end
    end

    // Response monitor.
    sb_t e_mon;
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'(sb.size()), 64'd1);
            end else begin
                e_mon = sb.pop_front();
                rsp_cnt++;
                chk("rsp_err", 64'(bus.rsp_err), 64'(e_mon.err));
                chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e_mon.rdata));
                chk("rsp_cycle", 64'(cyc + 1), 64'(e_mon.due));
            end
        end
    end

    // Issue one request; returns the index of the clock edge that accepted it.
    task automatic send(input logic [AW-1:0] addr, input logic [NS-1:0] sel, input logic wr,
                        input logic [WW-1:0] wdata, input int waits, output longint acc);
        int    n;
        logic  oh;
        sb_t   e;
        xfer_t x;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_sel   = sel;
        bus.req_wr_rd = wr;
        bus.req_wdata = wdata;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 300);
        chk("req_ready_wait", 64'(bus.req_ready), 64'd1);
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            acc = 0;
            return;
        end
        acc = cyc + 1;
        oh  = ($countones(sel) == 1);
        e.rdata = '0;
        e.err   = !oh || (waits >= TO);
        if (!oh) begin
            e.due = acc + 1;
        end else if (waits < TO) begin
            e.due = acc + 3 + waits;
            if (wr) model_mem[addr] = wdata;
            else    e.rdata = model_mem[addr];
        end else begin
            e.due = acc + 2 + TO;
        end
        sb.push_back(e);
        exp_rsp++;
        if (oh) begin
            x.waits = waits; x.addr = addr; x.sel = sel; x.wr = wr; x.wdata = wdata;
            xq.push_back(x);
            exp_xfers++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.req_valid = 1'b0;
        while (sb.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        longint a0, a1, a2;
        int     x0, r, gap, waits;
        logic [NS-1:0] sel_opts [4];
        sel_opts[0] = 2'b01; sel_opts[1] = 2'b10; sel_opts[2] = 2'b11; sel_opts[3] = 2'b00;

        for (int i = 0; i < 32; i++) begin
            slv_mem[i]   = $urandom;
            model_mem[i] = slv_mem[i];
        end
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_sel   = '0;
        bus.req_wr_rd = 1'b0;
        bus.req_wdata = '0;
        bus.apb_ready = 1'b0;
        bus.apb_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("reset_apb_sel", 64'(bus.apb_sel), 64'd0);
        chk("reset_apb_enable", 64'(bus.apb_enable), 64'd0);
        chk("reset_apb_addr", 64'(bus.apb_addr), 64'd0);
        chk("reset_apb_wdata", 64'(bus.apb_wdata), 64'd0);
        chk("reset_apb_wstrobe", 64'(bus.apb_wstrobe), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Zero-wait write, then a read with three wait states.
        send(5'h04, 2'b01, 1'b1, 32'hDEADBEEF, 0, a0);
        drain();
        chk("slave_reg4", 64'(slv_mem[4]), 64'hDEADBEEF);
        send(5'h09, 2'b10, 1'b1, 32'h12345678, 0, a0);
        send(5'h09, 2'b10, 1'b0, 32'h0, 3, a0);
        drain();

        // Timeout and the boundary either side of it.
        send(5'h02, 2'b01, 1'b0, 32'h0, 100, a0);
        send(5'h03, 2'b10, 1'b0, 32'h0, TO - 1, a0);
        send(5'h05, 2'b01, 1'b1, 32'hCAFEF00D, TO, a0);
        send(5'h05, 2'b01, 1'b0, 32'h0, 0, a0);
        drain();

        // Bad selects never reach the bus.
        x0 = xfers;
        send(5'h01, 2'b11, 1'b1, 32'h11111111, 0, a0);
        send(5'h01, 2'b00, 1'b0, 32'h0, 0, a0);
        drain();
        repeat (3) @(negedge clk);
        chk("bad_sel_no_xfer", 64'(xfers), 64'(x0));
        @(posedge clk);
        #1;

        // Reset while the slave is stalling.
        send(5'h07, 2'b01, 1'b0, 32'h0, 100, a0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        exp_rsp -= sb.size();
        sb.delete();
        @(negedge clk);
        chk("rst_mid_apb_sel", 64'(bus.apb_sel), 64'd0);
        chk("rst_mid_apb_enable", 64'(bus.apb_enable), 64'd0);
        chk("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_mid_req_ready", 64'(bus.req_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(5'h07, 2'b01, 1'b0, 32'h0, 1, a0);
        drain();

        // Back-to-back reads with req_valid held throughout.
        send(5'h04, 2'b01, 1'b0, 32'h0, 0, a0);
        send(5'h09, 2'b10, 1'b0, 32'h0, 0, a1);
        send(5'h05, 2'b01, 1'b0, 32'h0, 0, a2);
        drain();
        chk("btb_spacing_1", 64'(a1 - a0), 64'd4);
        chk("btb_spacing_2", 64'(a2 - a1), 64'd4);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      waits = $urandom_range(0, 2);
            else if (r < 8) waits = $urandom_range(3, TO - 1);
            else            waits = $urandom_range(TO, TO + 4);
            r = $urandom_range(0, 9);
            send(5'($urandom_range(0, 31)), sel_opts[r < 8 ? (r % 2) : (r - 6)],
                 1'($urandom_range(0, 1)), $urandom, waits, a0);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                bus.req_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        drain();

        chk("apb_xfer_count", 64'(xfers), 64'(exp_xfers));
        chk("rsp_count", 64'(rsp_cnt), 64'(exp_rsp));
        chk("xfer_queue_empty", 64'(xq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
